// File: rtl/otter_pkg.sv
// Shared OTTER decode encodings: ALU codes, opcodes, operand selects,
// branch kinds and the registered control bundle handed to execute.
package otter_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_LUI  = 4'b1001
   } alu_fun_t;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_t;

   typedef enum logic [1:0] {
      SRCB_RS2 = 2'd0,
      SRCB_IMM = 2'd1,
      SRCB_PC  = 2'd2
   } srcb_sel_t;

   typedef enum logic [2:0] {
      BR_NONE   = 3'd0,
      BR_BRANCH = 3'd1,
      BR_JAL    = 3'd2,
      BR_JALR   = 3'd3
   } br_type_t;

   typedef struct packed {
      alu_fun_t   alu_fun;
      logic       srca_sel;
      srcb_sel_t  srcb_sel;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_we;
      logic       mem_we;
      logic       mem_re;
      br_type_t   br_type;
      logic [2:0] funct3;
      logic       illegal;
   } id_ctrl_t;

endpackage

// File: rtl/otter_decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle
// of the OTTER decode stage.
interface otter_decode_stage_if #(
   parameter int XLEN = 32
);

   logic [31:0]     IR;
   logic [XLEN-1:0] PC_IN;
   logic            IN_VALID;
   logic            IN_READY;
   logic            FLUSH;
   logic            OUT_READY;
   logic            OUT_VALID;
   logic [XLEN-1:0] PC_OUT;
   logic [3:0]      ALU_FUN;
   logic            SRCA_SEL;
   logic [1:0]      SRCB_SEL;
   logic [XLEN-1:0] IMM;
   logic [4:0]      RS1;
   logic [4:0]      RS2;
   logic [4:0]      RD;
   logic            REG_WE;
   logic            MEM_WE;
   logic            MEM_RE;
   logic [2:0]      BR_TYPE;
   logic [2:0]      FUNCT3;
   logic            ILLEGAL;

   modport master (
      output IR, PC_IN, IN_VALID, FLUSH, OUT_READY,
      input  IN_READY, OUT_VALID, PC_OUT, ALU_FUN,
      input  SRCA_SEL, SRCB_SEL, IMM, RS1, RS2, RD,
      input  REG_WE, MEM_WE, MEM_RE, BR_TYPE, FUNCT3,
      input  ILLEGAL
   );

   modport slave (
      input  IR, PC_IN, IN_VALID, FLUSH, OUT_READY,
      output IN_READY, OUT_VALID, PC_OUT, ALU_FUN,
      output SRCA_SEL, SRCB_SEL, IMM, RS1, RS2, RD,
      output REG_WE, MEM_WE, MEM_RE, BR_TYPE, FUNCT3,
      output ILLEGAL
   );

endinterface

// File: rtl/otter_imm_gen.sv
// RV32I immediate extraction: I/S/B/U/J forms, sign-extended
// from IR[31] to XLEN.
module otter_imm_gen #(
   parameter int XLEN = 32
) (
   input  logic [31:7]     ir,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_b,
   output logic [XLEN-1:0] imm_u,
   output logic [XLEN-1:0] imm_j
);

   logic [31:0] i32;
   logic [31:0] s32;
   logic [31:0] b32;
   logic [31:0] u32;
   logic [31:0] j32;

   always_comb begin
      i32 = {{20{ir[31]}}, ir[31:20]};
      s32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      b32 = {{19{ir[31]}}, ir[31], ir[7],
             ir[30:25], ir[11:8], 1'b0};
      u32 = {ir[31:12], 12'h000};
      j32 = {{11{ir[31]}}, ir[31], ir[19:12],
             ir[20], ir[30:21], 1'b0};
   end

   // signed casts widen past 32 bits when XLEN is larger
   assign imm_i = XLEN'($signed(i32));
   assign imm_s = XLEN'($signed(s32));
   assign imm_b = XLEN'($signed(b32));
   assign imm_u = XLEN'($signed(u32));
   assign imm_j = XLEN'($signed(j32));

endmodule

// File: rtl/otter_decode_stage.sv
// OTTER RV32I decode stage: one-cycle registered decode with
// valid/ready on both sides and flush of the held slot.
module otter_decode_stage
   import otter_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                CLK,
   input logic                RST_N,
   otter_decode_stage_if.slave bus
);

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_sh;

   otter_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .ir    (bus.IR[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   logic [6:0] op;
   logic [2:0] f3;
   logic       is_shift;

   assign op       = bus.IR[6:0];
   assign f3       = bus.IR[14:12];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
   assign imm_sh   = {{(XLEN-5){1'b0}}, bus.IR[24:20]};

   id_ctrl_t        dec;
   logic [XLEN-1:0] dec_imm;

   always_comb begin
      dec         = '0;
      dec_imm     = '0;
      dec.rs1     = bus.IR[19:15];
      dec.rs2     = bus.IR[24:20];
      dec.rd      = bus.IR[11:7];
      dec.funct3  = f3;
      dec.alu_fun = ALU_ADD;
      dec.br_type = BR_NONE;
      dec.srcb_sel = SRCB_RS2;
      unique case (op)
         OPC_OP: begin
            dec.alu_fun = alu_fun_t'({bus.IR[30], f3});
            dec.reg_we  = 1'b1;
         end
         OPC_OP_IMM: begin
            // IR[30] only selects SRA vs SRL; ADDI keeps ADD
            dec.alu_fun  = alu_fun_t'(
               {(f3 == 3'b101) ? bus.IR[30] : 1'b0, f3});
            dec.srcb_sel = SRCB_IMM;
            dec.reg_we   = 1'b1;
            dec_imm      = is_shift ? imm_sh : imm_i;
         end
         OPC_LUI: begin
            dec.alu_fun  = ALU_LUI;
            dec.srca_sel = 1'b1;
            dec.reg_we   = 1'b1;
            dec_imm      = imm_u;
         end
         OPC_AUIPC: begin
            dec.srca_sel = 1'b1;
            dec.srcb_sel = SRCB_PC;
            dec.reg_we   = 1'b1;
            dec_imm      = imm_u;
         end
         OPC_LOAD: begin
            dec.srcb_sel = SRCB_IMM;
            dec.mem_re   = 1'b1;
            dec.reg_we   = 1'b1;
            dec_imm      = imm_i;
         end
         OPC_STORE: begin
            dec.srcb_sel = SRCB_IMM;
            dec.mem_we   = 1'b1;
            dec_imm      = imm_s;
         end
         OPC_BRANCH: begin
            dec.br_type = BR_BRANCH;
            dec_imm     = imm_b;
         end
         OPC_JAL: begin
            dec.br_type = BR_JAL;
            dec.reg_we  = 1'b1;
            dec_imm     = imm_j;
         end
         OPC_JALR: begin
            dec.br_type  = BR_JALR;
            dec.srcb_sel = SRCB_IMM;
            dec.reg_we   = 1'b1;
            dec_imm      = imm_i;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      if (dec.rd == 5'd0) dec.reg_we = 1'b0;
   end

   logic            out_valid;
   logic            load;
   id_ctrl_t        ctrl_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] imm_q;

   assign bus.IN_READY = !out_valid || bus.OUT_READY;
   assign load = bus.IN_VALID && bus.IN_READY && !bus.FLUSH;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid <= 1'b0;
      end else if (bus.FLUSH) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
      end else if (bus.OUT_READY) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ctrl_q <= '0;
         pc_q   <= RESET_PC;
         imm_q  <= '0;
      end else if (load) begin
         ctrl_q <= dec;
         pc_q   <= bus.PC_IN;
         imm_q  <= dec_imm;
      end
   end

   assign bus.OUT_VALID = out_valid;
   assign bus.PC_OUT    = pc_q;
   assign bus.IMM       = imm_q;
   assign bus.ALU_FUN   = ctrl_q.alu_fun;
   assign bus.SRCA_SEL  = ctrl_q.srca_sel;
   assign bus.SRCB_SEL  = ctrl_q.srcb_sel;
   assign bus.RS1       = ctrl_q.rs1;
   assign bus.RS2       = ctrl_q.rs2;
   assign bus.RD        = ctrl_q.rd;
   assign bus.REG_WE    = ctrl_q.reg_we;
   assign bus.MEM_WE    = ctrl_q.mem_we;
   assign bus.MEM_RE    = ctrl_q.mem_re;
   assign bus.BR_TYPE   = ctrl_q.br_type;
   assign bus.FUNCT3    = ctrl_q.funct3;
   assign bus.ILLEGAL   = ctrl_q.illegal;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Directed bench for otter_decode_stage with a behavioural
// reference model checked on every falling clock edge.
module tb_otter_decode_stage;

   localparam int          XLEN   = 32;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   n_checks = 0;
   int   n_fails = 0;

   otter_decode_stage_if #(.XLEN(XLEN)) bus ();

   otter_decode_stage #(
      .XLEN     (XLEN),
      .RESET_PC (RST_PC)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic        srca;
      logic [1:0]  srcb;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        mem_we;
      logic        mem_re;
      logic [2:0]  br;
      logic [2:0]  f3;
      logic        ill;
   } exp_t;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference decode written from the instruction-set rules
   function automatic exp_t model(input logic [31:0] ir,
                                  input logic [31:0] pc);
      exp_t        e;
      logic [2:0]  f;
      logic [31:0] ii, si, bi, ui, ji;
      e = '{default: '0};
      f = ir[14:12];
      ii = 32'($signed(ir[31:20]));
      si = 32'($signed({ir[31:25], ir[11:7]}));
      bi = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8]})) << 1;
      ji = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21]})) << 1;
      ui = ir & 32'hFFFF_F000;
      e.pc  = pc;
      e.rs1 = ir[19:15];
      e.rs2 = ir[24:20];
      e.rd  = ir[11:7];
      e.f3  = f;
      case (ir[6:0])
         7'h33: begin
            e.alu = {ir[30], f};
            e.reg_we = 1;
         end
         7'h13: begin
            e.alu = (f == 3'd5) ? {ir[30], f} : {1'b0, f};
            e.srcb = 2'd1;
            e.imm = (f == 3'd1 || f == 3'd5) ? 32'(ir[24:20]) : ii;
            e.reg_we = 1;
         end
         7'h37: begin
            e.alu = 4'd9; e.srca = 1; e.imm = ui; e.reg_we = 1;
         end
         7'h17: begin
            e.srca = 1; e.srcb = 2'd2; e.imm = ui; e.reg_we = 1;
         end
         7'h03: begin
            e.srcb = 2'd1; e.imm = ii; e.mem_re = 1; e.reg_we = 1;
         end
         7'h23: begin
            e.srcb = 2'd1; e.imm = si; e.mem_we = 1;
         end
         7'h63: begin
            e.imm = bi; e.br = 3'd1;
         end
         7'h6F: begin
            e.imm = ji; e.br = 3'd2; e.reg_we = 1;
         end
         7'h67: begin
            e.srcb = 2'd1; e.imm = ii; e.br = 3'd3; e.reg_we = 1;
         end
         default: e.ill = 1;
      endcase
      if (e.rd == 5'd0) e.reg_we = 0;
      return e;
   endfunction

   logic m_valid;
   exp_t m;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_valid = 1'b0;
         m = '{default: '0};
         m.pc = RST_PC;
      end else if (bus.FLUSH) begin
         m_valid = 1'b0;
      end else if (bus.IN_VALID && (!m_valid || bus.OUT_READY)) begin
         m_valid = 1'b1;
         m = model(bus.IR, bus.PC_IN);
      end else if (bus.OUT_READY) begin
         m_valid = 1'b0;
      end
   end

   always @(negedge CLK) begin
      check("in_ready", 32'(bus.IN_READY),
            32'(!m_valid || bus.OUT_READY));
      check("out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
      if (m_valid) begin
         check("m.pc", bus.PC_OUT, m.pc);
         check("m.alu", 32'(bus.ALU_FUN), 32'(m.alu));
         check("m.srca", 32'(bus.SRCA_SEL), 32'(m.srca));
         check("m.srcb", 32'(bus.SRCB_SEL), 32'(m.srcb));
         check("m.imm", bus.IMM, m.imm);
         check("m.rs1", 32'(bus.RS1), 32'(m.rs1));
         check("m.rs2", 32'(bus.RS2), 32'(m.rs2));
         check("m.rd", 32'(bus.RD), 32'(m.rd));
         check("m.reg_we", 32'(bus.REG_WE), 32'(m.reg_we));
         check("m.mem_we", 32'(bus.MEM_WE), 32'(m.mem_we));
         check("m.mem_re", 32'(bus.MEM_RE), 32'(m.mem_re));
         check("m.br", 32'(bus.BR_TYPE), 32'(m.br));
         check("m.f3", 32'(bus.FUNCT3), 32'(m.f3));
         check("m.ill", 32'(bus.ILLEGAL), 32'(m.ill));
      end
   end

   task automatic issue(input logic [31:0] ir,
                        input logic [31:0] pc);
      bus.IR = ir;
      bus.PC_IN = pc;
      bus.IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      bus.IN_VALID = 1'b0;
   endtask

   initial begin
      bus.IR = '0;
      bus.PC_IN = '0;
      bus.IN_VALID = 1'b0;
      bus.FLUSH = 1'b0;
      bus.OUT_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("rst.valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst.pc", bus.PC_OUT, RST_PC);
      check("rst.alu", 32'(bus.ALU_FUN), 32'd0);
      check("rst.imm", bus.IMM, 32'd0);
      check("rst.reg_we", 32'(bus.REG_WE), 32'd0);
      check("rst.ill", 32'(bus.ILLEGAL), 32'd0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      issue(32'h002081B3, 32'h100);
      check("add.valid", 32'(bus.OUT_VALID), 32'd1);
      check("add.alu", 32'(bus.ALU_FUN), 32'h0);
      check("add.rs1", 32'(bus.RS1), 32'd1);
      check("add.rs2", 32'(bus.RS2), 32'd2);
      check("add.rd", 32'(bus.RD), 32'd3);
      check("add.reg_we", 32'(bus.REG_WE), 32'd1);
      check("add.srcb", 32'(bus.SRCB_SEL), 32'd0);
      check("add.pc", bus.PC_OUT, 32'h100);
      issue(32'h402081B3, 32'h104);
      check("sub.alu", 32'(bus.ALU_FUN), 32'h8);
      issue(32'h40335293, 32'h108);
      check("srai.alu", 32'(bus.ALU_FUN), 32'hD);
      check("srai.imm", bus.IMM, 32'h3);
      check("srai.srcb", 32'(bus.SRCB_SEL), 32'd1);
      issue(32'h123450B7, 32'h10C);
      check("lui.alu", 32'(bus.ALU_FUN), 32'h9);
      check("lui.srca", 32'(bus.SRCA_SEL), 32'd1);
      check("lui.imm", bus.IMM, 32'h12345000);
      issue(32'hFFF00093, 32'h110);
      check("addi.alu", 32'(bus.ALU_FUN), 32'h0);
      check("addi.imm", bus.IMM, 32'hFFFFFFFF);
      issue(32'hFE208EE3, 32'h114);
      check("beq.imm", bus.IMM, 32'hFFFFFFFC);
      check("beq.br", 32'(bus.BR_TYPE), 32'd1);
      check("beq.reg_we", 32'(bus.REG_WE), 32'd0);
      issue(32'h008000EF, 32'h118);
      check("jal.imm", bus.IMM, 32'h8);
      check("jal.br", 32'(bus.BR_TYPE), 32'd2);
      check("jal.reg_we", 32'(bus.REG_WE), 32'd1);
      issue(32'hFE20AC23, 32'h11C);
      check("sw.imm", bus.IMM, 32'hFFFFFFF8);
      check("sw.mem_we", 32'(bus.MEM_WE), 32'd1);
      check("sw.reg_we", 32'(bus.REG_WE), 32'd0);
      issue(32'h00001217, 32'h120);
      check("auipc.imm", bus.IMM, 32'h1000);
      check("auipc.srcb", 32'(bus.SRCB_SEL), 32'd2);
      issue(32'h00000013, 32'h124);
      check("x0.reg_we", 32'(bus.REG_WE), 32'd0);
      @(posedge CLK);
      #1;
      check("drain.valid", 32'(bus.OUT_VALID), 32'd0);

      bus.OUT_READY = 1'b0;
      issue(32'h402081B3, 32'h200);
      bus.IR = 32'hFFF00093;
      bus.PC_IN = 32'h204;
      bus.IN_VALID = 1'b1;
      #1;
      check("bp.in_ready", 32'(bus.IN_READY), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         check("bp.hold_valid", 32'(bus.OUT_VALID), 32'd1);
         check("bp.hold_alu", 32'(bus.ALU_FUN), 32'h8);
         check("bp.hold_pc", bus.PC_OUT, 32'h200);
      end
      bus.OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      check("bp.next_valid", 32'(bus.OUT_VALID), 32'd1);
      check("bp.next_pc", bus.PC_OUT, 32'h204);
      check("bp.next_imm", bus.IMM, 32'hFFFFFFFF);

      bus.IR = 32'h123450B7;
      bus.PC_IN = 32'h208;
      bus.FLUSH = 1'b1;
      #1;
      check("fl.in_ready", 32'(bus.IN_READY), 32'd1);
      @(posedge CLK);
      #1;
      bus.FLUSH = 1'b0;
      bus.IN_VALID = 1'b0;
      check("fl.valid", 32'(bus.OUT_VALID), 32'd0);
      @(posedge CLK);
      #1;
      check("fl.valid2", 32'(bus.OUT_VALID), 32'd0);

      bus.OUT_READY = 1'b0;
      issue(32'h402081B3, 32'h300);
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1;
      check("arst.valid", 32'(bus.OUT_VALID), 32'd0);
      check("arst.alu", 32'(bus.ALU_FUN), 32'h0);
      check("arst.pc", bus.PC_OUT, RST_PC);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      bus.OUT_READY = 1'b1;
      @(posedge CLK);
      #1;

      issue(32'h0000007F, 32'h400);
      check("ill.valid", 32'(bus.OUT_VALID), 32'd1);
      check("ill.ill", 32'(bus.ILLEGAL), 32'd1);
      check("ill.reg_we", 32'(bus.REG_WE), 32'd0);
      check("ill.alu", 32'(bus.ALU_FUN), 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/otter_decode_stage.md
Name: otter_decode_stage

Overview:
- Instruction-decode pipeline stage for the OTTER RV32I pipeline; it produces the 4-bit ALU_FUN code consumed by the execute-stage ALU.
- Registers decoded control fields, immediate and register addresses, with a valid/ready handshake on both sides.
- Sits between the fetch stage and the execute stage. Latency is 1 cycle, with back-pressure and flush support.

Parameters:
- XLEN, 32, datapath width for PC and immediate outputs.
- RESET_PC, 32'h0000_0000, reset value driven on PC_OUT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IR  in  32  instruction word from fetch.
- PC_IN  in  XLEN  PC of IR.
- IN_VALID  in  1  fetch presents a valid IR/PC_IN.
- IN_READY  out  1  stage can accept an instruction this cycle.
- FLUSH  in  1  kill the held instruction (branch mispredict / jump).
- OUT_READY  in  1  execute stage accepts the held instruction.
- OUT_VALID  out  1  held instruction is valid.
- PC_OUT  out  XLEN  registered PC.
- ALU_FUN  out  4  ALU operation code.
- SRCA_SEL  out  1  0 = rs1, 1 = U-immediate.
- SRCB_SEL  out  2  0 = rs2, 1 = IMM, 2 = PC.
- IMM  out  XLEN  sign-extended immediate.
- RS1, RS2, RD  out  5 each  register addresses.
- REG_WE  out  1  writes RD.
- MEM_WE, MEM_RE  out  1 each  store / load.
- BR_TYPE  out  3  0 = none, 1 = branch (funct3 carried in FUNCT3), 2 = JAL, 3 = JALR.
- FUNCT3  out  3  registered IR[14:12].
- ILLEGAL  out  1  unsupported opcode.

Behaviour:
- Reset (RST_N low, asynchronous):
  - OUT_VALID = 0 and PC_OUT = RESET_PC.
  - Every other registered output = 0, which includes ALU_FUN = 4'b0000 (ADD).
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY. This is combinational, with no FLUSH term.
  - Load occurs when IN_VALID && IN_READY && !FLUSH. All output registers capture the decode of IR/PC_IN, and OUT_VALID becomes 1 at the next edge.
- Hold: when OUT_VALID && !OUT_READY, all outputs remain stable until accepted.
- Drain: on OUT_READY with no load, OUT_VALID becomes 0. Data registers may keep stale values.
- FLUSH has highest priority. At the next edge OUT_VALID = 0, and any concurrent load is discarded. The fetch-side handshake still completes, so the fetch stage treats that IR as consumed.
- ALU_FUN encoding (shared package):
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LUI 1001.
- Decode rules by opcode:
  - OP (0110011): ALU_FUN = {IR[30], funct3}; SRCB_SEL = 0; REG_WE = 1.
  - OP-IMM (0010011): ALU_FUN = {(funct3==3'b101) ? IR[30] : 1'b0, funct3}; SRCB_SEL = 1; I-immediate. This makes ADDI with IR[30]=1 stay ADD.
  - LUI (0110111): ALU_FUN = LUI; SRCA_SEL = 1; IMM = {IR[31:12], 12'h0}.
  - AUIPC (0010111): ALU_FUN = ADD; SRCA_SEL = 1; SRCB_SEL = 2.
  - LOAD (0000011): ADD with I-immediate; MEM_RE = 1; REG_WE = 1.
  - STORE (0100011): ADD with S-immediate; MEM_WE = 1; REG_WE = 0.
  - BRANCH (1100011): B-immediate; BR_TYPE = 1; REG_WE = 0.
  - JAL (1101111): J-immediate; BR_TYPE = 2; REG_WE = 1.
  - JALR (1100111): I-immediate; BR_TYPE = 3; REG_WE = 1.
  - Any other opcode: ILLEGAL = 1; REG_WE, MEM_WE and MEM_RE = 0; ALU_FUN = ADD. It still flows through the handshake.
- Immediates:
  - Sign bit is always IR[31], extended to XLEN.
  - B and J immediates have bit 0 = 0.
- Writes to x0: if RD == 0 then REG_WE = 0 (write to x0 suppressed).
- RS1 = IR[19:15] and RS2 = IR[24:20], raw for all formats.

Decomposition:
- Package otter_pkg holds:
  - the alu_fun_t enum (the codes above);
  - the opcode_t enum;
  - the srcb_sel_t enum;
  - the br_type_t enum.
- Sub-module otter_imm_gen is combinational: IR in, I/S/B/U/J immediates out. It is instantiated once.
- The decode itself is a single always_comb block feeding the output register.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), IN_VALID=1, OUT_READY=1 → next cycle OUT_VALID=1, ALU_FUN=0000, RS1=1, RS2=2, RD=3, REG_WE=1, SRCB_SEL=0.
- SUB x3,x1,x2 (0x402081B3) → ALU_FUN=1000. Then SRAI x5,x6,3 (0x40335293) → ALU_FUN=1101, IMM=0x00000003, SRCB_SEL=1.
- LUI x1,0x12345 (0x123450B7) → ALU_FUN=1001, SRCA_SEL=1, IMM=0x12345000. ADDI x1,x0,-1 (0xFFF00093) → ALU_FUN=0000, IMM=0xFFFFFFFF.
- Back-pressure: hold OUT_READY=0 for 3 cycles with a new IR offered → IN_READY=0 and outputs stable. Release → the held instruction drains and the next loads the same cycle, with no bubble.
- FLUSH asserted with IN_VALID=1 and OUT_VALID=1 → next cycle OUT_VALID=0, and that IR never appears on the outputs.
- RST_N dropped mid-hold, asynchronously between edges → OUT_VALID=0 and ALU_FUN=0000 immediately, PC_OUT=RESET_PC. Illegal opcode 0x0000007F → ILLEGAL=1, REG_WE=0.
